// File: rtl/core_pkg.sv
// Shared widths, reset vector and the fetch buffer entry type for the instruction front end.
package core_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_INST_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] addr;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; registered output, no write-to-read bypass.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]         wptr_q, rptr_q;
  logic [CNT_W-1:0]         count_q;
  logic                     do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: owns the fetch PC, keeps reads in flight, buffers in-order responses
// and drops stale ones after a redirect.
module inst_prefetch
  import core_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = DEF_ADDR_W,
  parameter int unsigned        INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [INST_W-1:0] ibus_rdata_i,
  input  logic              ibus_err_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_err_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    in_use;
  logic              fifo_empty, fifo_full;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic              gnt_fire;
  logic [ADDR_W-1:0] jump_target;
  fetch_entry_t      push_entry, head_entry;

  // Slots are reserved at grant time so a returning response always has room.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign ibus_req_o  = !rst_i && (in_use < (CNT_W + 1)'(DEPTH));
  assign ibus_addr_o = fetch_pc_q;
  assign gnt_fire    = ibus_req_o && ibus_gnt_i;
  assign jump_target = jump_addr_i & ~ADDR_W'(3);

  assign outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(ibus_rvalid_i);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (jump_flag_i) begin
      fifo_flush = 1'b1;
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      // Every read still owed to us after this edge belongs to the old path.
      discard_d  = outstanding_d;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (ibus_rvalid_i) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + ADDR_W'(4);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign push_entry = '{inst: ibus_rdata_i, addr: resp_pc_q, err: ibus_err_i};
  assign fifo_pop   = inst_valid_o && inst_ready_i && !jump_flag_i;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head_entry),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Outputs are masked when empty so stale storage never leaks out.
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = inst_valid_o ? head_entry.inst : '0;
  assign inst_addr_o  = inst_valid_o ? head_entry.addr : '0;
  assign inst_err_o   = inst_valid_o ? head_entry.err  : 1'b0;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (fifo_full && fifo_push) |-> fifo_pop);

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: bus model with controllable response release and an
// expected-instruction scoreboard filled at grant time, flushed on redirect.
module tb_inst_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_err;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] popped[$];
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          checks = 0;
  int          failures = 0;
  int          n_pops;
  int          n_grants;

  always #5 clk = ~clk;

  inst_prefetch #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .jump_flag_i   (jump_flag),
    .jump_addr_i   (jump_addr),
    .ibus_req_o    (ibus_req),
    .ibus_addr_o   (ibus_addr),
    .ibus_gnt_i    (ibus_gnt),
    .ibus_rvalid_i (ibus_rvalid),
    .ibus_rdata_i  (ibus_rdata),
    .ibus_err_i    (ibus_err),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr),
    .inst_err_o    (inst_err)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  // One bus cycle, entered and left at a falling edge: consume the head if accepted, then drive
  // gnt/response/ready/jump for the coming rising edge.
  task automatic tick(input bit g, input bit r, input bit j, input logic [31:0] ja, input bit re);
    ent_t        e;
    logic [31:0] pa;
    bit          fire;
    if (!j && inst_valid && r) begin
      n_pops++;
      popped.push_back(inst_addr);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got addr=%h inst=%h, no instruction expected", inst_addr,
                 inst);
      end else begin
        e = exp_q.pop_front();
        if ({inst_addr, inst, inst_err} !== {e.a, e.d, e.e}) begin
          failures++;
          $display("FAIL sb_entry: got addr=%h inst=%h err=%b, want addr=%h inst=%h err=%b",
                   inst_addr, inst, inst_err, e.a, e.d, e.e);
        end
      end
    end
    inst_ready = r;
    jump_flag  = j;
    jump_addr  = ja;
    if (re && pend_q.size() > 0) begin
      pa          = pend_q.pop_front();
      ibus_rvalid = 1'b1;
      ibus_rdata  = memf(pa);
      ibus_err    = (pa == err_addr);
    end else begin
      ibus_rvalid = 1'b0;
      ibus_rdata  = '0;
      ibus_err    = 1'b0;
    end
    fire     = ibus_req && g;
    ibus_gnt = g;
    if (j) exp_q.delete();
    if (fire) begin
      pend_q.push_back(ibus_addr);
      n_grants++;
      if (!j) exp_q.push_back('{a: ibus_addr, d: memf(ibus_addr), e: (ibus_addr == err_addr)});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ibus_gnt = 0; ibus_rvalid = 0; ibus_rdata = '0; ibus_err = 0;
    jump_flag = 0; jump_addr = '0; inst_ready = 0;
    exp_q.delete(); pend_q.delete(); popped.delete();
    n_pops = 0; n_grants = 0; err_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ibus_gnt = 0; ibus_rvalid = 0; ibus_rdata = '0; ibus_err = 0;
    jump_flag = 0; jump_addr = '0; inst_ready = 0;
    @(negedge clk);
    checks++;
    if ({ibus_req, inst_valid, inst, inst_addr, inst_err} !== 67'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b valid=%b inst=%h addr=%h err=%b, want all 0",
               ibus_req, inst_valid, inst, inst_addr, inst_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h, want req=1 addr=00000000", ibus_req,
               ibus_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    inst_ready = 1'b1;
    tick(1, 1, 0, 0, 1);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_latency0: valid=%b, want 0 before any response", inst_valid);
    end
    tick(1, 1, 0, 0, 1);
    checks++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
      failures++;
      $display("FAIL stream_latency1: valid=%b addr=%h, want 1/00000000", inst_valid, inst_addr);
    end
    for (int i = 2; i < 20; i++) tick(1, 1, 0, 0, 1);
    checks++;
    if (n_pops !== 18) begin
      failures++;
      $display("FAIL stream_throughput: pops=%0d, want 18", n_pops);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 1);
    checks++;
    if (n_grants !== 4) begin
      failures++;
      $display("FAIL bp_grants: grants=%0d, want 4", n_grants);
    end
    checks++;
    if (ibus_req !== 1'b0 || inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
      failures++;
      $display("FAIL bp_hold: req=%b valid=%b addr=%h, want 0/1/00000000", ibus_req,
               inst_valid, inst_addr);
    end
    tick(1, 1, 0, 0, 1);
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h10) begin
      failures++;
      $display("FAIL bp_refill: req=%b addr=%h, want 1/00000010", ibus_req, ibus_addr);
    end
    tick(1, 0, 0, 0, 1);
    checks++;
    if (ibus_req !== 1'b0 || n_grants !== 5) begin
      failures++;
      $display("FAIL bp_one_more: req=%b grants=%0d, want 0/5", ibus_req, n_grants);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0);
    tick(1, 1, 1, 32'h103, 0);
    checks++;
    if (inst_valid !== 1'b0 || ibus_req !== 1'b0 || n_grants !== 4) begin
      failures++;
      $display("FAIL redir_after: valid=%b req=%b grants=%0d, want 0/0/4", inst_valid,
               ibus_req, n_grants);
    end
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0, 1);
    checks++;
    if (popped.size() == 0 || popped[0] !== 32'h100) begin
      failures++;
      $display("FAIL redir_target: first addr=%h count=%0d, want 00000100", 
               (popped.size() > 0) ? popped[0] : 32'hx, popped.size());
    end
  endtask

  task automatic test_rvalid_jump();
    do_reset();
    tick(1, 1, 0, 0, 0);
    tick(0, 1, 1, 32'h200, 1);
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL rvj_empty: valid=%b, want 0", inst_valid);
    end
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin
      failures++;
      $display("FAIL rvj_req: req=%b addr=%h, want 1/00000200", ibus_req, ibus_addr);
    end
    for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, 1);
    checks++;
    if (popped.size() == 0 || popped[0] !== 32'h200) begin
      failures++;
      $display("FAIL rvj_target: first addr=%h count=%0d, want 00000200",
               (popped.size() > 0) ? popped[0] : 32'hx, popped.size());
    end
  endtask

  task automatic test_bus_err();
    do_reset();
    err_addr = 32'h8;
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, 1);
    checks++;
    if (popped.size() < 4 || popped[2] !== 32'h8 || popped[3] !== 32'hC) begin
      failures++;
      $display("FAIL err_continue: pops=%0d, want 0x8 then 0xC delivered", popped.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++;
    if (inst_valid !== 1'b1 || pend_q.size() !== 2) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%b inflight=%0d, want 1/2", inst_valid, pend_q.size());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ibus_req, inst_valid, inst, inst_addr, inst_err} !== 67'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: req=%b valid=%b inst=%h addr=%h err=%b, want all 0",
               ibus_req, inst_valid, inst, inst_addr, inst_err);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); pend_q.delete(); popped.delete();
    ibus_rvalid = 0; ibus_gnt = 0;
    #1;
    checks++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_req: req=%b addr=%h, want 1/00000000", ibus_req, ibus_addr);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, 1);
    checks++;
    if (popped.size() == 0 || popped[0] !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_restart: first addr=%h count=%0d, want 00000000",
               (popped.size() > 0) ? popped[0] : 32'hx, popped.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_rvalid_jump();
    test_bus_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
